// File: rtl/vec_operand_fetch_pkg.sv
// rtl/vec_operand_fetch_pkg.sv - shared widths and FIFO entry type for the vector operand fetch unit
// Default geometry constants and the entry that travels from the VRF read
// port through the output FIFO.
package vec_operand_fetch_pkg;

  localparam int VOF_ADDR_W = 5;
  localparam int VOF_OFF_W  = 8;
  localparam int VOF_DATA_W = 32;
  localparam int VOF_DEPTH  = 4;

  typedef struct packed {
    logic [VOF_DATA_W-1:0] data;
    logic                  is_start;
    logic                  is_end;
  } vof_entry_t;

  function automatic vof_entry_t vof_make_entry(input logic [VOF_DATA_W-1:0] d,
                                                input logic s,
                                                input logic e);
    vof_entry_t r;
    r.data     = d;
    r.is_start = s;
    r.is_end   = e;
    return r;
  endfunction

endpackage

// File: rtl/vec_operand_fetch_if.sv
// rtl/vec_operand_fetch_if.sv - request, VRF read and output stream bundle for vec_operand_fetch
// slave is the fetch unit's view, master is the surrounding pipeline's view.
interface vec_operand_fetch_if
  import vec_operand_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = VOF_ADDR_W,
  parameter int OFF_WIDTH  = VOF_OFF_W,
  parameter int DATA_WIDTH = VOF_DATA_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [OFF_WIDTH-1:0]  off_in;
  logic                  start_in;
  logic                  end_in;

  logic                  vrf_rd_en;
  logic [ADDR_WIDTH-1:0] vrf_rd_addr;
  logic [OFF_WIDTH-1:0]  vrf_rd_off;
  logic [DATA_WIDTH-1:0] vrf_rd_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_start;
  logic                  out_end;

  logic                  flush;
  logic                  busy;

  modport slave (
    input  in_valid, addr_in, off_in, start_in, end_in,
    input  vrf_rd_data, out_ready, flush,
    output in_ready, vrf_rd_en, vrf_rd_addr, vrf_rd_off,
    output out_valid, out_data, out_start, out_end, busy
  );

  modport master (
    output in_valid, addr_in, off_in, start_in, end_in,
    output vrf_rd_data, out_ready, flush,
    input  in_ready, vrf_rd_en, vrf_rd_addr, vrf_rd_off,
    input  out_valid, out_data, out_start, out_end, busy
  );

endinterface

// File: rtl/vof_fifo.sv
// rtl/vof_fifo.sv - power-of-two output FIFO holding fetched elements and their group tags
// Storage is not reset; only pointers and count are. clr empties in one cycle
// and wins over a same-cycle push or pop.
module vof_fifo
  import vec_operand_fetch_pkg::*;
#(
  parameter int DEPTH = VOF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  vof_entry_t             push_entry,
  input  logic                   pop,
  output vof_entry_t             head_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  vof_entry_t    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  assign empty      = (count_q == '0);
  assign do_pop     = pop & ~empty;
  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/vec_operand_fetch.sv
// rtl/vec_operand_fetch.sv - VRF operand fetch: accept requests, read the VRF, queue results (VOF_BYPASS_EN: empty-FIFO bypass)
// The VRF answers one cycle after the read, so accepted requests hold a FIFO
// slot via pending until their data lands. busy tracks an open group.
module vec_operand_fetch
  import vec_operand_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = VOF_ADDR_W,
  parameter int OFF_WIDTH  = VOF_OFF_W,
  parameter int DATA_WIDTH = VOF_DATA_W,
  parameter int DEPTH      = VOF_DEPTH
) (
  input logic                clk,
  input logic                rst_n,
  vec_operand_fetch_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occupancy;
  logic          fifo_empty;
  logic          in_ready;
  logic          accept;
  logic          out_valid;
  logic          deliver;
  logic          push;
  logic          pop;
  logic          bypass_avail;
  logic          bypass_take;

  logic          pending_q, pending_d;
  logic          tag_start_q, tag_start_d;
  logic          tag_end_q, tag_end_d;
  logic          busy_q, busy_d;

  vof_entry_t    pend_entry;
  vof_entry_t    head_entry;
  vof_entry_t    out_entry;

  // A slot is reserved for the in-flight read, so the FIFO can never overflow.
  assign occupancy = fifo_count + CW'(pending_q);
  assign in_ready  = rst_n & ~bus.flush & (occupancy < CW'(DEPTH));
  assign accept    = bus.in_valid & in_ready;

  assign bus.in_ready    = in_ready;
  assign bus.vrf_rd_en   = accept;
  assign bus.vrf_rd_addr = ADDR_WIDTH'(bus.addr_in);
  assign bus.vrf_rd_off  = OFF_WIDTH'(bus.off_in);

  assign pend_entry = vof_make_entry(VOF_DATA_W'(bus.vrf_rd_data), tag_start_q, tag_end_q);

`ifdef VOF_BYPASS_EN
  // Returning data may go straight out when nothing older is queued.
  assign bypass_avail = pending_q & fifo_empty & ~bus.flush;
`else
  assign bypass_avail = 1'b0;
`endif

  assign out_valid   = rst_n & (~fifo_empty | bypass_avail);
  assign out_entry   = fifo_empty ? pend_entry : head_entry;
  assign deliver     = out_valid & bus.out_ready;
  assign pop         = deliver & ~fifo_empty;
  assign bypass_take = deliver & fifo_empty;
  assign push        = pending_q & ~bus.flush & ~bypass_take;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = DATA_WIDTH'(out_entry.data);
  assign bus.out_start = out_entry.is_start;
  assign bus.out_end   = out_entry.is_end;
  assign bus.busy      = busy_q;

  vof_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (bus.flush),
    .push       (push),
    .push_entry (pend_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

  // Next pending/tag/busy; a new start outranks a same-cycle end, flush outranks both.
  always_comb begin
    pending_d   = accept;
    tag_start_d = tag_start_q;
    tag_end_d   = tag_end_q;
    busy_d      = busy_q;
    if (accept) begin
      tag_start_d = bus.start_in;
      tag_end_d   = bus.end_in;
    end
    if (deliver && out_entry.is_end) busy_d = 1'b0;
    if (accept && bus.start_in)      busy_d = 1'b1;
    if (bus.flush)                   busy_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q   <= 1'b0;
      tag_start_q <= 1'b0;
      tag_end_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      tag_start_q <= tag_start_d;
      tag_end_q   <= tag_end_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_vec_operand_fetch.sv
// tb/tb_vec_operand_fetch.sv - self-checking bench for vec_operand_fetch
module tb_vec_operand_fetch;

`ifdef VOF_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
    bit          ok;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_req;
  int   tests_run;
  int   tests_failed;

  logic [31:0] vrf_mem [32][256];
  logic [4:0]  r_addr [256];
  logic [7:0]  r_off [256];
  logic        r_s [256];
  logic        r_e [256];

  ent_t exp_q[$];
  ent_t exp_out_q[$];
  ent_t got_q[$];

  always #5 clk = ~clk;

  vec_operand_fetch_if vif ();

  vec_operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  // VRF model: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    vif.vrf_rd_data <= vif.vrf_rd_en ? vrf_mem[vif.vrf_rd_addr][vif.vrf_rd_off] : $urandom;
  end

  // Reference model: outstanding accepted elements in order; flush/reset drop them.
  always @(negedge clk) begin
    if (vif.out_valid && vif.out_ready) begin
      got_q.push_back('{vif.out_data, vif.out_start, vif.out_end, 1'b1});
      if (exp_q.size() > 0) exp_out_q.push_back(exp_q.pop_front());
      else exp_out_q.push_back('{32'h0, 1'b0, 1'b0, 1'b0});
    end
    if (vif.in_valid && vif.in_ready)
      exp_q.push_back('{vrf_mem[vif.addr_in][vif.off_in], vif.start_in, vif.end_in, 1'b1});
    if (vif.flush || !rst_n) exp_q.delete();
  end

  task automatic step(input logic v, input logic [4:0] a, input logic [7:0] o,
                      input logic s, input logic e, input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    rst_n         = rst_req;
    vif.in_valid  = v;
    vif.addr_in   = a;
    vif.off_in    = o;
    vif.start_in  = s;
    vif.end_in    = e;
    vif.out_ready = rdy;
    vif.flush     = fl;
    @(negedge clk);
  endtask

  task automatic drain(output bit ok);
    int cyc = 0;
    step(0, 0, 0, 0, 0, 1, 0);
    while ((exp_q.size() != 0 || vif.out_valid) && cyc < 200) begin
      step(0, 0, 0, 0, 0, 1, 0);
      cyc++;
    end
    ok = (cyc < 200);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic gen_reqs(input int n, input int glen);
    int left = 0;
    for (int i = 0; i < n; i++) begin
      r_addr[i] = 5'($urandom);
      r_off[i]  = 8'($urandom);
      if (left == 0) begin
        left   = (glen == 0) ? $urandom_range(1, 5) : glen;
        r_s[i] = 1'b1;
      end else begin
        r_s[i] = 1'b0;
      end
      left--;
      r_e[i] = (left == 0) || (i == n - 1);
    end
  endtask

  task automatic run_stream(input int n, input int rmode, input int vpct, output bit ok);
    int   idx = 0;
    int   cyc = 0;
    logic rdy = 1'b1;
    logic v;
    bit   dok;
    while (idx < n && cyc < 4000) begin
      v = ($urandom_range(0, 99) < vpct);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        default: rdy = ($urandom_range(0, 99) < 60);
      endcase
      step(v, r_addr[idx], r_off[idx], r_s[idx], r_e[idx], rdy, 0);
      if (v && vif.in_ready) idx++;
      cyc++;
    end
    drain(dok);
    ok = (idx == n) && dok;
  endtask

  task automatic test_reset();
    rst_req = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 5'd3, 8'd0, 1, 1, 1, 0);
    tests_run++;
    if (vif.in_ready !== 1'b0 || vif.vrf_rd_en !== 1'b0 || vif.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: in_ready=%b vrf_rd_en=%b out_valid=%b expected 0 0 0",
               vif.in_ready, vif.vrf_rd_en, vif.out_valid);
    end
    tests_run++;
    if (vif.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b expected 0", vif.busy);
    end
    rst_req = 1'b1;
    step(0, 0, 0, 0, 0, 1, 0);
    tests_run++;
    if (vif.in_ready !== 1'b1 || vif.out_valid !== 1'b0 || vif.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b busy=%b expected 1 0 0",
               vif.in_ready, vif.out_valid, vif.busy);
    end
    got_q.delete();
    exp_out_q.delete();
  endtask

  task automatic test_single();
    int          lat = 0;
    logic [31:0] d = 0;
    logic        s = 0, e = 0, b = 0;
    step(1, 5'd3, 8'd0, 1, 1, 1, 0);
    tests_run++;
    if (vif.vrf_rd_en !== 1'b1 || vif.vrf_rd_addr !== 5'd3 || vif.vrf_rd_off !== 8'd0) begin
      tests_failed++;
      $display("FAIL single_rd_port: en=%b addr=%0d off=%0d expected 1 3 0",
               vif.vrf_rd_en, vif.vrf_rd_addr, vif.vrf_rd_off);
    end
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      if (vif.out_valid && lat == 0) begin
        lat = k;
        d   = vif.out_data;
        s   = vif.out_start;
        e   = vif.out_end;
        b   = vif.busy;
      end
    end
    tests_run++;
    if (lat != EXP_LAT) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d expected %0d", lat, EXP_LAT);
    end
    tests_run++;
    if (d !== 32'hA5 || s !== 1'b1 || e !== 1'b1 || b !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_data: data=%h start=%b end=%b busy=%b expected a5 1 1 1", d, s, e, b);
    end
    tests_run++;
    if (vif.busy !== 1'b0 || vif.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_after_pop: busy=%b out_valid=%b expected 0 0", vif.busy, vif.out_valid);
    end
    got_q.delete();
    exp_out_q.delete();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int cyc = 0;
    bit ok;
    gen_reqs(8, 8);
    for (int c = 0; c < 12; c++) begin
      step(1, r_addr[idx], r_off[idx], r_s[idx], r_e[idx], 0, 0);
      if (vif.in_ready) idx++;
    end
    tests_run++;
    if (idx != 4 || vif.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_accepts: accepts=%0d in_ready=%b expected 4 0", idx, vif.in_ready);
    end
    while (idx < 8 && cyc < 100) begin
      step(1, r_addr[idx], r_off[idx], r_s[idx], r_e[idx], 1, 0);
      if (vif.in_ready) idx++;
      cyc++;
    end
    drain(ok);
    tests_run++;
    if (!ok || got_q.size() != 8) begin
      tests_failed++;
      $display("FAIL bp_count: outputs=%0d drained=%0b expected 8 1", got_q.size(), ok);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      tests_run++;
      if (!exp_out_q[i].ok || got_q[i].d !== exp_out_q[i].d ||
          got_q[i].s !== exp_out_q[i].s || got_q[i].e !== exp_out_q[i].e) begin
        tests_failed++;
        $display("FAIL bp_item%0d: got %h/%b/%b expected %h/%b/%b known=%0b", i, got_q[i].d,
                 got_q[i].s, got_q[i].e, exp_out_q[i].d, exp_out_q[i].s, exp_out_q[i].e, exp_out_q[i].ok);
      end
    end
    got_q.delete();
    exp_out_q.delete();
  endtask

  task automatic test_wrap();
    bit ok;
    gen_reqs(12, 4);
    run_stream(12, 1, 100, ok);
    tests_run++;
    if (!ok || got_q.size() != 12) begin
      tests_failed++;
      $display("FAIL wrap_count: outputs=%0d done=%0b expected 12 1", got_q.size(), ok);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      tests_run++;
      if (!exp_out_q[i].ok || got_q[i].d !== exp_out_q[i].d ||
          got_q[i].s !== (i % 4 == 0) || got_q[i].e !== (i % 4 == 3)) begin
        tests_failed++;
        $display("FAIL wrap_item%0d: got %h/%b/%b expected %h/%b/%b", i, got_q[i].d,
                 got_q[i].s, got_q[i].e, exp_out_q[i].d, (i % 4 == 0), (i % 4 == 3));
      end
    end
    got_q.delete();
    exp_out_q.delete();
  endtask

  task automatic test_simultaneous();
    bit         ok;
    logic [4:0] a [4];
    for (int i = 0; i < 4; i++) a[i] = 5'($urandom);
    step(1, a[0], 8'd1, 1, 0, 0, 0);
    step(1, a[1], 8'd2, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (dut.u_fifo.count_q !== 3'd2) begin
      tests_failed++;
      $display("FAIL simul_setup_count: got %0d expected 2", dut.u_fifo.count_q);
    end
    step(1, a[2], 8'd3, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, a[3], 8'd4, 1, 1, 1, 0);
    tests_run++;
    if (dut.u_fifo.count_q !== 3'd2 || vif.out_end !== 1'b1 || vif.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_push_pop: count=%0d out_end=%b in_ready=%b expected 2 1 1",
               dut.u_fifo.count_q, vif.out_end, vif.in_ready);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (vif.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_busy_hold: got %b expected 1", vif.busy);
    end
    drain(ok);
    tests_run++;
    if (!ok || got_q.size() != 4 || vif.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_drain: outputs=%0d busy=%b expected 4 0", got_q.size(), vif.busy);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      tests_run++;
      if (!exp_out_q[i].ok || got_q[i].d !== exp_out_q[i].d ||
          got_q[i].s !== exp_out_q[i].s || got_q[i].e !== exp_out_q[i].e) begin
        tests_failed++;
        $display("FAIL simul_item%0d: got %h/%b/%b expected %h/%b/%b", i, got_q[i].d,
                 got_q[i].s, got_q[i].e, exp_out_q[i].d, exp_out_q[i].s, exp_out_q[i].e);
      end
    end
    got_q.delete();
    exp_out_q.delete();
  endtask

  task automatic test_flush();
    bit ok;
    step(1, 5'($urandom), 8'($urandom), 1, 0, 0, 0);
    step(1, 5'($urandom), 8'($urandom), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 5'($urandom), 8'($urandom), 0, 0, 0, 0);
    tests_run++;
    if (vif.vrf_rd_en !== 1'b1 || vif.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_setup: vrf_rd_en=%b busy=%b expected 1 1", vif.vrf_rd_en, vif.busy);
    end
    step(1, 5'($urandom), 8'($urandom), 0, 1, 0, 1);
    tests_run++;
    if (vif.in_ready !== 1'b0 || vif.vrf_rd_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_in_ready: in_ready=%b vrf_rd_en=%b expected 0 0", vif.in_ready, vif.vrf_rd_en);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (vif.out_valid !== 1'b0 || vif.busy !== 1'b0 || dut.u_fifo.count_q !== 3'd0) begin
      tests_failed++;
      $display("FAIL flush_empty: out_valid=%b busy=%b count=%0d expected 0 0 0",
               vif.out_valid, vif.busy, dut.u_fifo.count_q);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    tests_run++;
    if (vif.in_ready !== 1'b1 || vif.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_recover: in_ready=%b out_valid=%b expected 1 0", vif.in_ready, vif.out_valid);
    end
    drain(ok);
    tests_run++;
    if (!ok || got_q.size() != 0) begin
      tests_failed++;
      $display("FAIL flush_leak: outputs=%0d expected 0", got_q.size());
    end
    got_q.delete();
    exp_out_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    step(1, 5'($urandom), 8'($urandom), 1, 0, 0, 0);
    step(1, 5'($urandom), 8'($urandom), 0, 0, 0, 0);
    step(1, 5'($urandom), 8'($urandom), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (dut.u_fifo.count_q !== 3'd3 || vif.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_setup: count=%0d busy=%b expected 3 1", dut.u_fifo.count_q, vif.busy);
    end
    rst_req = 1'b0;
    step(1, 5'($urandom), 8'($urandom), 1, 1, 1, 0);
    rst_req = 1'b1;
    step(0, 0, 0, 0, 0, 1, 0);
    tests_run++;
    if (vif.out_valid !== 1'b0 || vif.busy !== 1'b0 || dut.u_fifo.count_q !== 3'd0) begin
      tests_failed++;
      $display("FAIL rmid_state: out_valid=%b busy=%b count=%0d expected 0 0 0",
               vif.out_valid, vif.busy, dut.u_fifo.count_q);
    end
    gen_reqs(4, 4);
    run_stream(4, 0, 100, ok);
    tests_run++;
    if (!ok || got_q.size() != 4) begin
      tests_failed++;
      $display("FAIL rmid_after: outputs=%0d expected 4", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      tests_run++;
      if (!exp_out_q[i].ok || got_q[i].d !== exp_out_q[i].d) begin
        tests_failed++;
        $display("FAIL rmid_item%0d: got %h expected %h", i, got_q[i].d, exp_out_q[i].d);
      end
    end
    got_q.delete();
    exp_out_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    gen_reqs(200, 0);
    run_stream(200, 2, 70, ok);
    tests_run++;
    if (!ok || got_q.size() != 200 || vif.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rand_count: outputs=%0d done=%0b busy=%b expected 200 1 0", got_q.size(), ok, vif.busy);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      tests_run++;
      if (!exp_out_q[i].ok || got_q[i].d !== exp_out_q[i].d ||
          got_q[i].s !== exp_out_q[i].s || got_q[i].e !== exp_out_q[i].e) begin
        tests_failed++;
        $display("FAIL rand_item%0d: got %h/%b/%b expected %h/%b/%b", i, got_q[i].d,
                 got_q[i].s, got_q[i].e, exp_out_q[i].d, exp_out_q[i].s, exp_out_q[i].e);
      end
    end
    got_q.delete();
    exp_out_q.delete();
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    rst_req       = 1'b0;
    vif.in_valid  = 1'b0;
    vif.addr_in   = '0;
    vif.off_in    = '0;
    vif.start_in  = 1'b0;
    vif.end_in    = 1'b0;
    vif.out_ready = 1'b0;
    vif.flush     = 1'b0;
    for (int a = 0; a < 32; a++)
      for (int o = 0; o < 256; o++)
        vrf_mem[a][o] = $urandom;
    vrf_mem[3][0] = 32'hA5;

    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vec_operand_fetch.md
VEC_OPERAND_FETCH -- requirements
Module: vec_operand_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, the vector register address width.
REQ-002 SHALL have parameter OFF_WIDTH, default 8, the intra-register element offset width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, the element width read from the VRF.
REQ-004 SHALL have parameter DEPTH, default 4, the output FIFO entries (power of two, >=2).
REQ-005 SHALL use one clock and a synchronous, active-low reset: clk  input  1  clock; rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have in_valid  input  1  address-generator element request valid.
REQ-007 SHALL have in_ready  output  1  request accepted this cycle when in_valid is also high.
REQ-008 SHALL have addr_in  input  ADDR_WIDTH  register address; off_in  input  OFF_WIDTH  element offset.
REQ-009 SHALL have start_in  input  1 and end_in  input  1  first/last element of the group.
REQ-010 SHALL have vrf_rd_en  output  1, vrf_rd_addr  output  ADDR_WIDTH, vrf_rd_off  output  OFF_WIDTH  VRF read port.
REQ-011 SHALL have vrf_rd_data  input  DATA_WIDTH  VRF read data, valid exactly 1 cycle after vrf_rd_en.
REQ-012 SHALL have out_valid  output  1, out_ready  input  1, out_data  output  DATA_WIDTH, out_start  output  1, out_end  output  1.
REQ-013 SHALL have flush  input  1  synchronous discard of all in-flight work.
REQ-014 SHALL have busy  output  1  a group is open (start accepted, end not yet delivered downstream).

Function
REQ-015 SHALL accept a request when in_valid & in_ready; vrf_rd_en SHALL equal that accept, combinationally, with vrf_rd_addr/off passing addr_in/off_in.
REQ-016 SHALL track pending = 1 in the cycle after an accept, 0 otherwise; in_ready = (count + pending) < DEPTH & ~flush.
REQ-017 SHALL write vrf_rd_data plus registered start/end tags into the FIFO in the cycle pending = 1 (unless bypassed, REQ-026).
REQ-018 SHALL drive out_valid = count != 0, out_data/out_start/out_end from FIFO head; pop on out_valid & out_ready.
REQ-019 Latency without bypass: accept at cycle T -> out_valid at T+2.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push into full FIFO SHALL be impossible by REQ-016.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; count SHALL span 0..DEPTH.
REQ-022 busy SHALL set on accept with start_in, clear on pop with out_end; accept with start_in and end_in (single element) SHALL set busy until that pop.
REQ-023 If set and clear of busy coincide (end popped while new start accepted), busy SHALL stay 1.
REQ-024 flush SHALL empty FIFO, clear pending and busy next cycle, and the VRF data returning the cycle after flush SHALL be discarded; in_ready SHALL be 0 during flush.

Reset
REQ-025 rst_n = 0 at a clk edge SHALL set count, pointers, pending, busy to 0; out_valid, in_ready-pending state, vrf_rd_en output 0 during reset; FIFO data not reset; reset mid-group discards everything as flush does.

Configuration
REQ-026 Macro VOF_BYPASS_EN defined: when count = 0 and pending = 1, out_valid SHALL be 1 with vrf_rd_data and the pending tags; if out_ready, the entry SHALL not be written to FIFO; latency T+1.
REQ-027 VOF_BYPASS_EN undefined: no bypass path; latency always T+2 per REQ-019.

Structure
REQ-028 Shared package SHALL hold the FIFO entry struct (data, start, end) and default width constants.
REQ-029 FIFO storage/pointers SHALL be one sub-module, vof_fifo; the top holds accept, pending, busy, bypass logic.

Verification
REQ-030 Single element: accept addr 3 off 0 start=end=1 at T, rd_data 0xA5 at T+1, out_ready=1 -> out_valid T+2 (T+1 with bypass), data 0xA5, start=end=1, busy 0 after pop.
REQ-031 Backpressure: 8-element group, out_ready=0, DEPTH 4 -> exactly 4 accepts, in_ready 0 thereafter; release out_ready -> 8 outputs in order, no loss or duplication.
REQ-032 Wrap: 3 back-to-back 4-element groups with out_ready toggling 1/0 -> order preserved across pointer wrap, start/end on elements 0/3 of each group.
REQ-033 Simultaneous: FIFO at count 2, push and pop same cycle -> count stays 2; end pop with new start accept -> busy stays 1.
REQ-034 Flush: flush the cycle after an accept with 2 entries queued -> out_valid 0 next cycle, returning rd_data never appears, busy 0, in_ready 1 two cycles later.
REQ-035 Reset mid-group: rst_n low 1 cycle with 3 entries queued -> out_valid 0, busy 0, count 0 after the edge.
